// File: rtl/free_list_ctrl_pkg.sv
// Shared constants and types for the physical-register free list controller.
// The free list holds every physical register not named by the retirement map.
package free_list_ctrl_pkg;

  localparam int FL_LANES       = 4;
  localparam int SIZE_PHYSICAL  = 64;
  localparam int SIZE_RMT       = 32;
  localparam int FL_DEPTH_DEF   = SIZE_PHYSICAL - SIZE_RMT;
  localparam int FL_INDEX_DEF   = $clog2(FL_DEPTH_DEF);
  localparam int PREG_WIDTH_DEF = $clog2(SIZE_PHYSICAL);

  typedef logic [PREG_WIDTH_DEF-1:0] preg_t;

endpackage

// File: rtl/fl_ptr_add.sv
// Modulo-FL_DEPTH pointer adder for pointer + 0..4; works for any depth,
// not just powers of two.
module fl_ptr_add
  import free_list_ctrl_pkg::*;
#(
  parameter int FL_DEPTH = FL_DEPTH_DEF,
  parameter int FL_INDEX = FL_INDEX_DEF
) (
  input  logic [FL_INDEX-1:0] ptr,
  input  logic [2:0]          inc,
  output logic [FL_INDEX-1:0] sum
);

  localparam int SW = FL_INDEX + 2;

  logic [SW-1:0] raw;

  always_comb begin
    raw = SW'(ptr) + SW'(inc);
    if (raw >= SW'(2 * FL_DEPTH)) begin
      raw = raw - SW'(2 * FL_DEPTH);
    end else if (raw >= SW'(FL_DEPTH)) begin
      raw = raw - SW'(FL_DEPTH);
    end
    sum = raw[FL_INDEX-1:0];
  end

endmodule

// File: rtl/free_list_ctrl.sv
// Head/tail/occupancy controller for the 4R/4W free-list SRAM: hands out up to
// four free tags per cycle, accepts up to four released tags, reclaims on flush.
module free_list_ctrl
  import free_list_ctrl_pkg::*;
#(
  parameter int FL_DEPTH   = FL_DEPTH_DEF,
  parameter int FL_INDEX   = FL_INDEX_DEF,
  parameter int PREG_WIDTH = PREG_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            alloc_req_i,
  output logic                  alloc_grant_o,
  output logic [PREG_WIDTH-1:0] alloc_preg0_o,
  output logic [PREG_WIDTH-1:0] alloc_preg1_o,
  output logic [PREG_WIDTH-1:0] alloc_preg2_o,
  output logic [PREG_WIDTH-1:0] alloc_preg3_o,
  input  logic [3:0]            free_valid_i,
  input  logic [PREG_WIDTH-1:0] free_preg0_i,
  input  logic [PREG_WIDTH-1:0] free_preg1_i,
  input  logic [PREG_WIDTH-1:0] free_preg2_i,
  input  logic [PREG_WIDTH-1:0] free_preg3_i,
  input  logic                  recover_i,
  output logic [FL_INDEX-1:0]   fl_raddr0_o,
  output logic [FL_INDEX-1:0]   fl_raddr1_o,
  output logic [FL_INDEX-1:0]   fl_raddr2_o,
  output logic [FL_INDEX-1:0]   fl_raddr3_o,
  input  logic [PREG_WIDTH-1:0] fl_rdata0_i,
  input  logic [PREG_WIDTH-1:0] fl_rdata1_i,
  input  logic [PREG_WIDTH-1:0] fl_rdata2_i,
  input  logic [PREG_WIDTH-1:0] fl_rdata3_i,
  output logic [FL_INDEX-1:0]   fl_waddr0_o,
  output logic [FL_INDEX-1:0]   fl_waddr1_o,
  output logic [FL_INDEX-1:0]   fl_waddr2_o,
  output logic [FL_INDEX-1:0]   fl_waddr3_o,
  output logic                  fl_we0_o,
  output logic                  fl_we1_o,
  output logic                  fl_we2_o,
  output logic                  fl_we3_o,
  output logic [PREG_WIDTH-1:0] fl_wdata0_o,
  output logic [PREG_WIDTH-1:0] fl_wdata1_o,
  output logic [PREG_WIDTH-1:0] fl_wdata2_o,
  output logic [PREG_WIDTH-1:0] fl_wdata3_o,
  output logic [FL_INDEX:0]     free_count_o,
  output logic                  overflow_err_o
);

  localparam int CW = FL_INDEX + 1;
  localparam int SW = FL_INDEX + 2;

  logic [FL_INDEX-1:0]   head, tail, head_next, tail_next;
  logic [CW-1:0]         count;
  logic                  err;
  logic [FL_INDEX-1:0]   raddr [FL_LANES];
  logic [FL_INDEX-1:0]   waddr [FL_LANES];
  logic [PREG_WIDTH-1:0] rdata [FL_LANES];
  logic [PREG_WIDTH-1:0] fpreg [FL_LANES];
  logic [PREG_WIDTH-1:0] wdata [FL_LANES];
  logic [PREG_WIDTH-1:0] apreg [FL_LANES];
  logic [1:0]            a_slot [FL_LANES];
  logic [1:0]            f_slot [FL_LANES];
  logic [2:0]            n_a, n_f, alloc_amt;
  logic [3:0]            we;
  logic                  grant, ovf;
  logic [SW-1:0]         cnt_sum;

  assign rdata[0] = fl_rdata0_i;
  assign rdata[1] = fl_rdata1_i;
  assign rdata[2] = fl_rdata2_i;
  assign rdata[3] = fl_rdata3_i;
  assign fpreg[0] = free_preg0_i;
  assign fpreg[1] = free_preg1_i;
  assign fpreg[2] = free_preg2_i;
  assign fpreg[3] = free_preg3_i;

  // Slot of each lane = number of active lanes below it.
  always_comb begin
    n_a = '0;
    n_f = '0;
    for (int k = 0; k < FL_LANES; k++) begin
      a_slot[k] = n_a[1:0];
      f_slot[k] = n_f[1:0];
      n_a = n_a + 3'(alloc_req_i[k]);
      n_f = n_f + 3'(free_valid_i[k]);
    end
  end

  // Frees are never fed into this check: a freed tag is only allocatable next cycle.
  assign grant     = reset & ~recover_i & (CW'(n_a) <= count);
  assign alloc_amt = grant ? n_a : 3'd0;

  always_comb begin
    for (int k = 0; k < FL_LANES; k++) begin
      apreg[k] = rdata[a_slot[k]];
      wdata[k] = '0;
    end
    for (int k = 0; k < FL_LANES; k++) begin
      if (free_valid_i[k]) wdata[f_slot[k]] = fpreg[k];
    end
    for (int j = 0; j < FL_LANES; j++) begin
      we[j] = reset & (3'(j) < n_f);
    end
  end

  for (genvar k = 0; k < FL_LANES; k++) begin : g_addr
    fl_ptr_add #(.FL_DEPTH(FL_DEPTH), .FL_INDEX(FL_INDEX)) u_radd (
      .ptr(head), .inc(3'(k)), .sum(raddr[k])
    );
    fl_ptr_add #(.FL_DEPTH(FL_DEPTH), .FL_INDEX(FL_INDEX)) u_wadd (
      .ptr(tail), .inc(3'(k)), .sum(waddr[k])
    );
  end

  fl_ptr_add #(.FL_DEPTH(FL_DEPTH), .FL_INDEX(FL_INDEX)) u_head_add (
    .ptr(head), .inc(alloc_amt), .sum(head_next)
  );
  fl_ptr_add #(.FL_DEPTH(FL_DEPTH), .FL_INDEX(FL_INDEX)) u_tail_add (
    .ptr(tail), .inc(n_f), .sum(tail_next)
  );

  assign cnt_sum = SW'(count) - SW'(alloc_amt) + SW'(n_f);
  assign ovf     = cnt_sum > SW'(FL_DEPTH);

  // Tail tracks the commit point, so a flush simply restarts allocation there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= CW'(FL_DEPTH);
      err   <= 1'b0;
    end else begin
      tail <= tail_next;
      if (ovf) err <= 1'b1;
      if (recover_i) begin
        head  <= tail_next;
        count <= CW'(FL_DEPTH);
      end else begin
        head  <= head_next;
        count <= ovf ? CW'(FL_DEPTH) : cnt_sum[CW-1:0];
      end
    end
  end

  assign alloc_grant_o  = grant;
  assign alloc_preg0_o  = apreg[0];
  assign alloc_preg1_o  = apreg[1];
  assign alloc_preg2_o  = apreg[2];
  assign alloc_preg3_o  = apreg[3];
  assign fl_raddr0_o    = raddr[0];
  assign fl_raddr1_o    = raddr[1];
  assign fl_raddr2_o    = raddr[2];
  assign fl_raddr3_o    = raddr[3];
  assign fl_waddr0_o    = waddr[0];
  assign fl_waddr1_o    = waddr[1];
  assign fl_waddr2_o    = waddr[2];
  assign fl_waddr3_o    = waddr[3];
  assign fl_we0_o       = we[0];
  assign fl_we1_o       = we[1];
  assign fl_we2_o       = we[2];
  assign fl_we3_o       = we[3];
  assign fl_wdata0_o    = wdata[0];
  assign fl_wdata1_o    = wdata[1];
  assign fl_wdata2_o    = wdata[2];
  assign fl_wdata3_o    = wdata[3];
  assign free_count_o   = count;
  assign overflow_err_o = err;

endmodule

// File: doc/free_list_ctrl.md
# free_list_ctrl

Pointer and occupancy controller for the 4-read/4-write physical-register free list SRAM. Each cycle it hands up to four free physical registers to rename and accepts up to four released registers from retire. On a pipeline flush it reclaims all speculatively allocated registers. It sits between rename/retire and the free-list SRAM instance and is that SRAM's only master.

## Interface
Parameters:
- FL_DEPTH, 32, free-list entries (SIZE_PHYSICAL − SIZE_RMT); need not be a power of two
- FL_INDEX, 5, SRAM address width, ≥ clog2(FL_DEPTH)
- PREG_WIDTH, 6, physical register tag width

Ports (lane k = 0..3):
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low
- alloc_req_i  in  4  rename lanes needing a destination register; any mask is legal
- alloc_grant_o  out  1  whole request granted this cycle
- alloc_pregk_o  out  PREG_WIDTH  register for lane k; valid only when alloc_req_i[k] and alloc_grant_o are both high
- free_valid_i  in  4  retire lanes releasing a register
- free_pregk_i  in  PREG_WIDTH  register released on lane k
- recover_i  in  1  flush: reclaim all uncommitted allocations
- fl_raddrk_o  out  FL_INDEX  SRAM read address k
- fl_rdatak_i  in  PREG_WIDTH  SRAM read data k (combinational read)
- fl_waddrk_o  out  FL_INDEX  SRAM write address k
- fl_wek_o  out  1  SRAM write enable k
- fl_wdatak_o  out  PREG_WIDTH  SRAM write data k
- free_count_o  out  FL_INDEX+1  number of free entries
- overflow_err_o  out  1  sticky error flag

## Operation
- State: head (next allocate), tail (next free write), count, sticky error.
- Allocation:
  - n_a = popcount(alloc_req_i).
  - fl_raddrk_o = head+k mod FL_DEPTH.
  - Requesting lane k takes slot popcount(alloc_req_i[k-1:0]) and reads its register from that slot's fl_rdata.
  - alloc_grant_o = reset high & !recover_i & n_a ≤ count. With n_a = 0 the grant is high and has no effect.
  - Allocation is all-or-nothing. A denied request leaves head and count unchanged.
- Free:
  - n_f = popcount(free_valid_i).
  - Valid lanes are compacted in lane order: the j-th valid lane writes address tail+j.
  - fl_wek_o[j] is high for j < n_f and low otherwise.
  - tail advances by n_f.
  - Frees are always accepted.
- Count update: count ← count − (granted ? n_a : 0) + n_f.
  - Same-cycle frees are not bypassed into the allocation check.
- Overflow: if count − allocated + n_f > FL_DEPTH, set overflow_err_o (sticky until reset) and saturate count at FL_DEPTH.
- Recover:
  - tail always equals the commit point, because each retiring destination frees exactly one older mapping.
  - Therefore recover sets head ← tail_next (including that cycle's frees) and count ← FL_DEPTH.
  - Allocation is suppressed in a recover cycle; frees in that cycle are still written.
- Pointer arithmetic: modulo FL_DEPTH, done by compare-and-subtract of at most 2·FL_DEPTH. No power-of-two wrap is assumed.

## Timing
- Reset (asynchronous, active-low): head = 0, tail = 0, count = FL_DEPTH, overflow_err_o = 0.
  - While reset is low: alloc_grant_o = 0, all fl_wek_o = 0, free_count_o = FL_DEPTH, fl_raddrk_o = k.
- Allocation is zero-latency: read addresses come from registered head, and grant and tags are combinational in the same cycle. The new head is visible the next cycle.
- Freed registers become allocatable the cycle after the write.
- Back-to-back allocate, free and recover in consecutive cycles are all legal.

## Structure
- Shared package holds:
  - lane count constant FL_LANES = 4
  - FL_DEPTH/FL_INDEX derivation from SIZE_PHYSICAL and SIZE_RMT
  - preg tag typedef
- One sub-module, fl_ptr_add: modulo-FL_DEPTH adder for pointer + 0..4. It is instantiated for the read addresses, write addresses, head_next and tail_next.
- Popcount/prefix-count logic stays inline.
- The SRAM is instantiated by the parent, not inside this block.

## Test plan
- Reset, then alloc_req_i = 1111 → grant = 1, tags 32, 33, 34, 35 (SRAM reset contents i+32); next cycle free_count_o = 28 and raddr0 = 4.
- Sparse mask 1010 at head = 4 → lane1 tag from entry 4, lane3 tag from entry 5; count drops by 2.
- count = 3 with request 1111 → grant = 0; head and count unchanged. Same cycle free_valid_i = 0011 → count = 5 next cycle; a retried request is granted.
- Wrap at head = 30, FL_DEPTH = 32 with request 1111 → read addresses 30, 31, 0, 1; head = 2.
- Free mask 0101 with tags 7, 9 at tail = 31 → writes 7→31 and 9→0 on write ports 0 and 1; tail = 1.
- Recover with free_valid_i = 0001 and tail = 10 → entry 10 written, head = 11, count = FL_DEPTH, grant = 0 that cycle.
- Free into a full list → overflow_err_o = 1 and held until reset; count stays FL_DEPTH.
- Assert reset mid-stream → outputs take their reset values immediately, without waiting for a clock edge.
